// File: rtl/pl_pkg.sv
// Shared definitions for the PLCPU pipeline.
//   XLEN             : architectural data/address width
//   NOP_INST         : canonical bubble instruction (addi x0, x0, 0)
//   DEFAULT_RESET_PC : PC value taken out of reset unless overridden
//   fetch_state_t    : fetch FSM states (RUN, HALT)
package pl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pl_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold, bubble-load and asynchronous reset.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   hold          : keep the current contents
//   bubble        : load an invalid NOP (wins over hold)
//   next_pc/pc4/inst : instruction loaded when neither hold nor bubble
//   valid, pc, pc4, inst : registered IF/ID contents
module if_id_reg
  import pl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] next_pc4,
  input  logic [XLEN-1:0] next_inst,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      pc4   <= 32'd4;
      inst  <= NOP_INST;
    end else if (bubble) begin
      // pc/pc4 keep their last value; only valid and inst mark the bubble
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (!hold) begin
      valid <= 1'b1;
      pc    <= next_pc;
      pc4   <= next_pc4;
      inst  <= next_inst;
    end
  end

endmodule

// File: rtl/pl_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and loads the IF/ID register. Obeys hazard-unit stalls and
// EX-stage redirects, and stops fetching once the PC passes the last
// instruction of the loaded program.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall_i         : load-use stall, freezes PC and IF/ID (ignored in HALT)
//   flush_i         : taken branch/jump, redirect to redirect_pc_i
//   redirect_pc_i   : redirect target, low two bits dropped
//   imem_addr_o     : byte address to instruction memory (always the PC)
//   imem_rdata_i    : combinational instruction word at imem_addr_o
//   if_id_*_o       : IF/ID register contents
//   halted_o        : fetch has stopped past MAX_INST_ADDR
//   fetch_count_o   : saturating count of valid instructions loaded
module pl_fetch_stage
  import pl_pkg::*;
#(
  parameter int              IMEM_DEPTH    = 1024,
  parameter logic [XLEN-1:0] MAX_INST_ADDR = 32'h34,
  parameter logic [XLEN-1:0] RESET_PC      = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [XLEN-1:0] if_id_inst_o,
  output logic            halted_o,
  output logic [XLEN-1:0] fetch_count_o
);

  // One extra bit so IMEM_DEPTH*4 cannot overflow the comparison.
  localparam logic [XLEN:0] IMEM_BYTES = {1'b0, 32'(IMEM_DEPTH)} << 2;

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next, pc_plus4, target;
  logic            ifid_hold, ifid_bubble, count_inc;
  logic            unused_redirect_low;

  assign target              = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc_i[1:0];
  assign pc_plus4            = pc + 32'd4;
  assign imem_addr_o         = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      halted_o      <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      // Registered alongside the state so it is high in the first HALT cycle.
      halted_o <= (state_next == HALT);
      if (count_inc) fetch_count_o <= sat_inc(fetch_count_o);
    end
  end

  // Priority: flush > stall > halt check > normal fetch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    if (flush_i) begin
      pc_next     = target;
      ifid_bubble = 1'b1;
      if (target > MAX_INST_ADDR || {1'b0, target} >= IMEM_BYTES)
        state_next = HALT;
      else
        state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (stall_i) begin
            ifid_hold = 1'b1;
          end else if (pc > MAX_INST_ADDR) begin
            state_next  = HALT;
            ifid_bubble = 1'b1;
          end else begin
            pc_next   = pc_plus4;
            count_inc = 1'b1;
          end
        end
        HALT: begin
          ifid_bubble = 1'b1;
        end
      endcase
    end
  end

  // IF -> ID stage boundary
  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (ifid_hold),
    .bubble    (ifid_bubble),
    .next_pc   (pc),
    .next_pc4  (pc_plus4),
    .next_inst (imem_rdata_i),
    .valid     (if_id_valid_o),
    .pc        (if_id_pc_o),
    .pc4       (if_id_pc4_o),
    .inst      (if_id_inst_o)
  );

endmodule

// File: tb/tb_pl_fetch_stage.sv
// Directed testbench for pl_fetch_stage with a combinational instruction
// memory whose word at byte address A is 32'hA5000000 ^ A.
module tb_pl_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        halted;
  logic [31:0] fetch_count;

  int vectors;
  int errors;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  pl_fetch_stage #(
    .IMEM_DEPTH    (1024),
    .MAX_INST_ADDR (32'h34),
    .RESET_PC      (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_id_valid_o (if_id_valid),
    .if_id_pc_o    (if_id_pc),
    .if_id_pc4_o   (if_id_pc4),
    .if_id_inst_o  (if_id_inst),
    .halted_o      (halted),
    .fetch_count_o (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    #12;
    vectors++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_id_valid); end
    vectors++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
    vectors++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", if_id_pc4); end
    vectors++; if (if_id_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", if_id_inst, NOP); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    vectors++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    do_reset();
  endtask

  task automatic test_straight_line();
    logic [31:0] a;
    for (int i = 0; i < 14; i++) begin
      tick();
      a = 32'(i) * 4;
      vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== a) begin errors++; $display("FAIL line_pc got %0b/%h exp 1/%h", if_id_valid, if_id_pc, a); end
      vectors++; if (if_id_pc4 !== a + 4 || if_id_inst !== word_at(a)) begin errors++; $display("FAIL line_data got %h/%h exp %h/%h", if_id_pc4, if_id_inst, a + 4, word_at(a)); end
      vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL line_halted_early got %0b exp 0 at %h", halted, a); end
    end
    tick();
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL line_halted got %0b exp 1", halted); end
    vectors++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin errors++; $display("FAIL line_bubble got %0b/%h exp 0/%h", if_id_valid, if_id_inst, NOP); end
    vectors++; if (fetch_count !== 32'd14) begin errors++; $display("FAIL line_count got %0d exp 14", fetch_count); end
    stall = 1'b1;
    tick(); tick();
    stall = 1'b0;
    vectors++; if (fetch_count !== 32'd14 || halted !== 1'b1) begin errors++; $display("FAIL line_count_hold got %0d/%0b exp 14/1", fetch_count, halted); end
    vectors++; if (imem_addr !== 32'h38 || if_id_valid !== 1'b0) begin errors++; $display("FAIL line_addr_hold got %h/%0b exp 38/0", imem_addr, if_id_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%0b exp 4/1", if_id_pc, if_id_valid); end
      vectors++; if (imem_addr !== 32'h8 || fetch_count !== 32'd2) begin errors++; $display("FAIL stall_pc got %h/%0d exp 8/2", imem_addr, fetch_count); end
    end
    stall = 1'b0;
    tick();
    vectors++; if (if_id_pc !== 32'h8 || if_id_inst !== word_at(32'h8)) begin errors++; $display("FAIL stall_release got %h/%h exp 8/%h", if_id_pc, if_id_inst, word_at(32'h8)); end
    vectors++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_flush_over_stall();
    do_reset();
    tick(); tick();
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
    tick();
    flush = 1'b0; stall = 1'b0;
    vectors++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin errors++; $display("FAIL flush_bubble got %0b/%h exp 0/%h", if_id_valid, if_id_inst, NOP); end
    vectors++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL flush_addr got %h exp 20", imem_addr); end
    tick();
    vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20) begin errors++; $display("FAIL flush_target got %0b/%h exp 1/20", if_id_valid, if_id_pc); end
    vectors++; if (if_id_inst !== word_at(32'h20) || fetch_count !== 32'd3) begin errors++; $display("FAIL flush_inst got %h/%0d exp %h/3", if_id_inst, fetch_count, word_at(32'h20)); end
  endtask

  task automatic test_redirect_halt();
    do_reset();
    tick();
    flush = 1'b1; redirect_pc = 32'h40;
    tick();
    flush = 1'b0;
    vectors++; if (halted !== 1'b1 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rhalt_enter got %0b/%0b exp 1/0", halted, if_id_valid); end
    vectors++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rhalt_addr got %h exp 40", imem_addr); end
    stall = 1'b1;
    tick(); tick();
    stall = 1'b0;
    vectors++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || fetch_count !== 32'd1) begin errors++; $display("FAIL rhalt_stay got %0b/%0b/%0d exp 1/0/1", halted, if_id_valid, fetch_count); end
    flush = 1'b1; redirect_pc = 32'h10;
    tick();
    flush = 1'b0;
    vectors++; if (halted !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL rhalt_leave got %0b/%h exp 0/10", halted, imem_addr); end
    tick();
    vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10) begin errors++; $display("FAIL rhalt_fetch got %0b/%h exp 1/10", if_id_valid, if_id_pc); end
    // Target beyond the memory but within range of MAX is not possible here;
    // check exact-boundary target MAX_INST_ADDR stays in RUN.
    flush = 1'b1; redirect_pc = 32'h34;
    tick();
    flush = 1'b0;
    vectors++; if (halted !== 1'b0 || imem_addr !== 32'h34) begin errors++; $display("FAIL rmax_run got %0b/%h exp 0/34", halted, imem_addr); end
    tick();
    vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h34) begin errors++; $display("FAIL rmax_fetch got %0b/%h exp 1/34", if_id_valid, if_id_pc); end
  endtask

  task automatic test_misaligned();
    do_reset();
    tick();
    flush = 1'b1; redirect_pc = 32'h13;
    tick();
    flush = 1'b0;
    vectors++; if (imem_addr !== 32'h10 || halted !== 1'b0) begin errors++; $display("FAIL misalign_addr got %h/%0b exp 10/0", imem_addr, halted); end
    tick();
    vectors++; if (if_id_pc !== 32'h10 || if_id_pc4 !== 32'h14) begin errors++; $display("FAIL misalign_pc got %h/%h exp 10/14", if_id_pc, if_id_pc4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin errors++; $display("FAIL areset_ifid got %0b/%h/%h exp 0/0/4", if_id_valid, if_id_pc, if_id_pc4); end
    vectors++; if (if_id_inst !== NOP || fetch_count !== 32'h0 || imem_addr !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL areset_ctrl got %h/%0d/%h/%0b exp %h/0/0/0", if_id_inst, fetch_count, imem_addr, halted, NOP); end
    #1;
    rst = 1'b0;
    tick();
    vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || fetch_count !== 32'd1) begin errors++; $display("FAIL areset_restart got %0b/%h/%0d exp 1/0/1", if_id_valid, if_id_pc, fetch_count); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_straight_line();
    test_stall();
    test_flush_over_stall();
    test_redirect_halt();
    test_misaligned();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
